arb_mux_2_1_rr: RTL and testbench



---
 rtl/arb_mux_2_1_rr.sv | 131 +++++++++++++
 tb/tb_arb_mux_2_1_rr.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_2_1_rr.sv
// Round-robin arbiter and sequencer for a shared 2:1 mux.
// Requesters A and B take turns owning a single registered output stage.
// Each grant is capped at MAX_BURST beats whenever the other side is waiting.
module arb_mux_2_1_rr #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,
    output logic             sel,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_A = 2'd1;
    localparam logic [1:0] GNT_B = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    // last: requester that most recently gave up the grant (0 = A, 1 = B).
    logic          last, last_nxt;

    logic          load;
    logic          xfer_a, xfer_b, xfer;
    logic          cur_valid, oth_valid, cur_id;
    logic [1:0]    other_state;

    // The output register can take a new beat when empty or being drained.
    assign load    = !y_valid || y_ready;
    assign a_ready = (state == GNT_A) && load;
    assign b_ready = (state == GNT_B) && load;
    assign sel     = (state == GNT_B);
    assign busy    = (state != IDLE) || y_valid;

    assign xfer_a  = a_valid && a_ready;
    assign xfer_b  = b_valid && b_ready;
    assign xfer    = xfer_a || xfer_b;

    // Views of the current grant holder and its competitor.
    assign cur_id      = (state == GNT_B);
    assign cur_valid   = cur_id ? b_valid : a_valid;
    assign oth_valid   = cur_id ? a_valid : b_valid;
    assign other_state = cur_id ? GNT_A : GNT_B;
    assign cnt_inc     = cnt + 1'b1;

    // Next grant, burst count and round-robin pointer.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_nxt = last ? GNT_A : GNT_B;
                end else if (a_valid) begin
                    state_nxt = GNT_A;
                end else if (b_valid) begin
                    state_nxt = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (!cur_valid) begin
                    // Holder has nothing more: hand over directly or go idle.
                    cnt_nxt   = '0;
                    last_nxt  = cur_id;
                    state_nxt = oth_valid ? other_state : IDLE;
                end else if (xfer) begin
                    if (cnt_inc == CW'(MAX_BURST)) begin
                        // Burst quota used up: yield if contended, else restart.
                        cnt_nxt = '0;
                        if (oth_valid) begin
                            state_nxt = other_state;
                            last_nxt  = cur_id;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // Single-stage output register; data holds when the stage empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (xfer_a) begin
            y_valid <= 1'b1;
            y_data  <= a_data;
        end else if (xfer_b) begin
            y_valid <= 1'b1;
            y_data  <= b_data;
        end else if (load) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb_mux_2_1_rr.sv
// Self-checking bench for arb_mux_2_1_rr: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_arb_mux_2_1_rr;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk;
    logic             rst_n;
    logic             a_valid, b_valid, y_ready;
    logic [WIDTH-1:0] a_data, b_data;
    logic             a_ready, b_ready, y_valid, sel, busy;
    logic [WIDTH-1:0] y_data;

    arb_mux_2_1_rr #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready),
        .sel     (sel),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner 0 = nobody, 1 = A, 2 = B; last uses the same ids.
    int               m_own, m_cnt, m_last;
    bit               m_yv;
    logic [WIDTH-1:0] m_yd;

    // Requester traffic sources and the expected output stream.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               stream_on;
    int unsigned      a_prob, b_prob, yr_prob;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_own  = 0;
        m_cnt  = 0;
        m_last = 2;
        m_yv   = 1'b0;
        m_yd   = '0;
    endtask

    // Present the next queued beat, holding an unaccepted one unchanged.
    task automatic drive(input bit xa, input bit xb);
        if (xa) void'(qa.pop_front());
        if (xb) void'(qb.pop_front());
        if (!(a_valid && !xa)) begin
            if (qa.size() > 0 && $urandom_range(99) < a_prob) begin
                a_valid = 1'b1;
                a_data  = qa[0];
            end else begin
                a_valid = 1'b0;
                a_data  = WIDTH'($urandom);
            end
        end
        if (!(b_valid && !xb)) begin
            if (qb.size() > 0 && $urandom_range(99) < b_prob) begin
                b_valid = 1'b1;
                b_data  = qb[0];
            end else begin
                b_valid = 1'b0;
                b_data  = WIDTH'($urandom);
            end
        end
        y_ready = ($urandom_range(99) < yr_prob);
    endtask

    // One clock: compare at the falling edge, advance the model, re-drive.
    task automatic step_cycle();
        bit               ld, ea, eb, xa, xb, mine, theirs;
        int               own_n, cnt_n, last_n;
        bit               yv_n;
        logic [WIDTH-1:0] yd_n;
        logic [31:0]      want;
        @(negedge clk);
        ld = !m_yv || y_ready;
        ea = (m_own == 1) && ld;
        eb = (m_own == 2) && ld;
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        check("y_valid", y_valid, m_yv);
        check("y_data", y_data, m_yd);
        check("sel", sel, m_own == 2);
        check("busy", busy, (m_own != 0) || m_yv);
        if (stream_on && m_yv && y_ready) begin
            want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF;
            check("stream", y_data, want);
        end
        xa = a_valid && ea;
        xb = b_valid && eb;
        yv_n = m_yv;
        yd_n = m_yd;
        if (xa) begin
            yv_n = 1'b1;
            yd_n = a_data;
        end else if (xb) begin
            yv_n = 1'b1;
            yd_n = b_data;
        end else if (ld) begin
            yv_n = 1'b0;
        end
        own_n  = m_own;
        cnt_n  = m_cnt;
        last_n = m_last;
        if (m_own == 0) begin
            if (a_valid && b_valid) own_n = (m_last == 1) ? 2 : 1;
            else if (a_valid) own_n = 1;
            else if (b_valid) own_n = 2;
        end else begin
            mine   = (m_own == 1) ? a_valid : b_valid;
            theirs = (m_own == 1) ? b_valid : a_valid;
            if (!mine) begin
                last_n = m_own;
                cnt_n  = 0;
                own_n  = theirs ? 3 - m_own : 0;
            end else if (xa || xb) begin
                cnt_n = m_cnt + 1;
                if (cnt_n == MAX_BURST) begin
                    cnt_n = 0;
                    if (theirs) begin
                        last_n = m_own;
                        own_n  = 3 - m_own;
                    end
                end
            end
        end
        @(posedge clk);
        m_own  = own_n;
        m_cnt  = cnt_n;
        m_last = last_n;
        m_yv   = yv_n;
        m_yd   = yd_n;
        #1;
        drive(xa, xb);
    endtask

    // Run until all traffic has drained, then confirm the block is idle.
    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (qa.size() == 0 && qb.size() == 0 && !a_valid && !b_valid &&
                m_own == 0 && !m_yv) break;
            step_cycle();
        end
        check("drain_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] cont_tab[16];
        cont_tab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80, 8'h81, 8'h82, 8'h83,
                     8'h04, 8'h05, 8'h06, 8'h07, 8'h84, 8'h85, 8'h86, 8'h87};
        rst_n   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        y_ready = 1'b1;
        a_prob  = 100;
        b_prob  = 100;
        yr_prob = 100;
        stream_on = 1'b0;
        m_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_sel", sel, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Contention: both always valid, bursts of MAX_BURST alternate.
        for (int i = 0; i < 8; i++) begin
            qa.push_back(WIDTH'(i));
            qb.push_back(WIDTH'(8'h80 + i));
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(cont_tab[i]);
        stream_on = 1'b1;
        drive(1'b0, 1'b0);
        drain();
        check("cont_left", exp_q.size(), 0);

        // Single beat latency.
        qa.push_back(8'h5A);
        exp_q.push_back(8'h5A);
        drive(1'b0, 1'b0);
        step_cycle();
        check("single_a_ready", a_ready, 1);
        step_cycle();
        check("single_y_valid", y_valid, 1);
        check("single_y_data", y_data, 8'h5A);
        step_cycle();
        check("single_busy", busy, 0);
        drain();

        // Backpressure in the middle of an A burst.
        for (int i = 0; i < 6; i++) begin
            qa.push_back(WIDTH'(8'h30 + i));
            exp_q.push_back(WIDTH'(8'h30 + i));
        end
        drive(1'b0, 1'b0);
        repeat (3) step_cycle();
        y_ready = 1'b0;
        yr_prob = 0;
        step_cycle();
        check("bp_a_ready", a_ready, 0);
        check("bp_hold", y_data, 8'h31);
        step_cycle();
        yr_prob = 100;
        step_cycle();
        drain();
        check("bp_left", exp_q.size(), 0);

        // Early release: A drops after 2 beats, B takes over at once.
        qa.push_back(8'h10);
        qa.push_back(8'h11);
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
        drive(1'b0, 1'b0);
        step_cycle();
        for (int i = 0; i < 5; i++) qb.push_back(WIDTH'(8'h20 + i));
        drive(1'b0, 1'b0);
        repeat (2) step_cycle();
        check("er_sel_before", sel, 0);
        step_cycle();
        check("er_sel_after", sel, 1);
        check("er_b_ready", b_ready, 1);
        drain();
        check("er_left", exp_q.size(), 0);

        // Randomized traffic and backpressure.
        stream_on = 1'b0;
        for (int i = 0; i < 200; i++) begin
            qa.push_back(WIDTH'($urandom));
            qb.push_back(WIDTH'($urandom));
        end
        a_prob  = 60;
        b_prob  = 60;
        yr_prob = 70;
        drive(1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            step_cycle();
        end
        check("rand_done", qa.size() + qb.size(), 0);
        a_prob  = 100;
        b_prob  = 100;
        yr_prob = 100;
        drain();

        // Asynchronous reset while B holds the grant mid-burst.
        for (int i = 0; i < 8; i++) qb.push_back(WIDTH'(8'h40 + i));
        drive(1'b0, 1'b0);
        repeat (3) step_cycle();
        a_valid = 1'b1;
        a_data  = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_y_valid", y_valid, 0);
        check("ar_y_data", y_data, 0);
        check("ar_sel", sel, 0);
        check("ar_a_ready", a_ready, 0);
        check("ar_b_ready", b_ready, 0);
        check("ar_busy", busy, 0);
        qa.delete();
        qb.delete();
        a_valid = 1'b0;
        b_valid = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First tie after reset goes to A.
        qa.push_back(8'h50);
        qb.push_back(8'h60);
        exp_q = '{8'h50, 8'h60};
        stream_on = 1'b1;
        drive(1'b0, 1'b0);
        step_cycle();
        check("tie_sel", sel, 0);
        check("tie_a_ready", a_ready, 1);
        drain();
        check("tie_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
